pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter and instruction-fetch unit for the next-generation processor data path. It owns the PC and the instruction register, and runs a request/acknowledge fetch handshake with instruction memory that tolerates variable wait states. It computes the next PC for increment, branch, jump and jump-register. It sits between the control unit, which issues FETCH and PC_UPDATE, and the memory port.

## Interface
- DATA_WIDTH, 32, instruction and register-data width.
- ADDR_WIDTH, 26, PC and memory address width; legal range 16..32.
- INST_START_ADDR, 'h1000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, wait-cycle limit before FAULT; only used when the watchdog is compiled in.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset; one clock, reset is synchronous and active-low.
- FETCH  in  1  request to fetch the instruction at the current PC.
- FLUSH  in  1  abort an in-flight fetch and clear FAULT.
- PC_UPDATE  in  1  load the next PC selected by NPC_SEL.
- NPC_SEL  in  2  next-PC source: 0 = PC+1, 1 = branch, 2 = jump, 3 = jump-register.
- RS_DATA  in  DATA_WIDTH  register operand for jump-register.
- MEM_REQ  out  1  fetch request to memory.
- MEM_ADDR  out  ADDR_WIDTH  fetch address (equals PC).
- MEM_RDATA  in  DATA_WIDTH  instruction word from memory.
- MEM_ACK  in  1  memory data valid.
- INSTRUCTION  out  DATA_WIDTH  instruction register.
- IR_VALID  out  1  one-cycle pulse when INSTRUCTION is updated.
- PC  out  ADDR_WIDTH  current PC.
- FAULT  out  1  sticky fetch timeout flag.

## Operation
- States: IDLE, REQ, VALID, FAULT.
- IDLE:
  - FETCH=1 moves to REQ.
  - PC_UPDATE=1 loads the next PC.
  - Both asserted in the same cycle are both accepted; the fetch uses the updated PC.
- REQ:
  - MEM_REQ=1 and MEM_ADDR=PC.
  - MEM_ACK=1 latches MEM_RDATA into INSTRUCTION and moves to VALID.
- VALID: IR_VALID=1 for one cycle, then return to IDLE. FETCH in VALID is ignored.
- FLUSH in REQ or VALID: return to IDLE and discard any same-cycle MEM_ACK. INSTRUCTION is unchanged and no IR_VALID pulse is issued.
- FLUSH in FAULT: clear FAULT and return to IDLE.
- PC_UPDATE outside IDLE is ignored and the PC holds.
- Next-PC arithmetic is modulo 2^ADDR_WIDTH, with PC1 = PC+1 (word addressing; wraps from all-ones to 0):
  - Branch: PC1 plus INSTRUCTION[15:0] sign-extended to ADDR_WIDTH.
  - Jump: {PC1[AW-1:26], INSTRUCTION[25:0]} when AW>26, otherwise INSTRUCTION[AW-1:0].
  - Jump-register: RS_DATA[AW-1:0].
- Branch and jump always use the latched INSTRUCTION, never MEM_RDATA.

## Timing
- Reset values:
  - PC = INST_START_ADDR.
  - INSTRUCTION = 0.
  - IR_VALID = 0, MEM_REQ = 0, FAULT = 0.
  - State = IDLE; the watchdog counter is 0.
- Reset mid-fetch abandons the request; MEM_REQ is low the cycle after the reset edge.
- MEM_REQ is registered: high the cycle after FETCH is accepted, low the cycle after ACK, FLUSH or timeout.
- Minimum fetch latency with zero-wait memory: FETCH at cycle N, MEM_REQ at N+1, ACK at N+1, IR_VALID at N+2.
- PC_UPDATE takes effect on PC at the next edge.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A counter runs in REQ, cleared on entry.
  - If it reaches TIMEOUT_CYCLES without MEM_ACK, the unit enters FAULT: FAULT=1, MEM_REQ=0, and FETCH is ignored until FLUSH or reset.
  - An ACK arriving in the same cycle as the limit is accepted and takes priority over the timeout.
- FETCH_TIMEOUT_EN undefined: no counter and no FAULT state; FAULT is tied to 0 and REQ waits indefinitely.

## Structure
- Package fetch_pkg holds:
  - NPC_INC, NPC_BRANCH, NPC_JUMP, NPC_JR encodings.
  - The state enum.
  - The immediate width (16) and jump-field width (26).
- Sub-module next_pc_calc: combinational next-PC computation from PC, INSTRUCTION, RS_DATA and NPC_SEL.
- The FSM, PC, IR and watchdog live in pc_fetch_unit.

## Test plan
- Reset then FETCH with a zero-wait ACK of 'h20010005: MEM_ADDR='h1000, INSTRUCTION='h20010005, one IR_VALID pulse, PC stays 'h1000.
- PC_UPDATE with NPC_SEL=1 and INSTRUCTION[15:0]='hFFFE at PC='h1000: PC becomes 'h0FFF. Repeat with NPC_SEL=2 and INSTRUCTION[25:0]='h0000040: PC becomes 'h40.
- FETCH and PC_UPDATE (NPC_SEL=0) asserted together at PC='h1000: MEM_ADDR='h1001.
- ACK held off 3 cycles, FLUSH in the 2nd wait cycle, ACK later: INSTRUCTION unchanged, no IR_VALID, MEM_REQ drops next cycle.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK: FAULT=1 after 4 REQ cycles and FETCH is ignored. FLUSH then clears it, and a new FETCH succeeds.
- With ADDR_WIDTH=16 and PC='hFFFF, NPC_SEL=0: PC wraps to 0. RST low during REQ: all outputs at reset values next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and field widths for the PC / instruction-fetch unit.
package fetch_pkg;

  localparam int unsigned IMM_WIDTH  = 16;
  localparam int unsigned JUMP_WIDTH = 26;

  typedef enum logic [1:0] {
    NPC_INC    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JR     = 2'd3
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control and instruction-memory signals of the fetch unit.
// The fetch unit takes the master side; control unit and memory model take the slave side.
interface pc_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26
);

  logic                  FETCH;
  logic                  FLUSH;
  logic                  PC_UPDATE;
  logic [1:0]            NPC_SEL;
  logic [DATA_WIDTH-1:0] RS_DATA;
  logic                  MEM_REQ;
  logic [ADDR_WIDTH-1:0] MEM_ADDR;
  logic [DATA_WIDTH-1:0] MEM_RDATA;
  logic                  MEM_ACK;
  logic [DATA_WIDTH-1:0] INSTRUCTION;
  logic                  IR_VALID;
  logic [ADDR_WIDTH-1:0] PC;
  logic                  FAULT;

  modport master (
    input  FETCH, FLUSH, PC_UPDATE, NPC_SEL, RS_DATA, MEM_RDATA, MEM_ACK,
    output MEM_REQ, MEM_ADDR, INSTRUCTION, IR_VALID, PC, FAULT
  );

  modport slave (
    output FETCH, FLUSH, PC_UPDATE, NPC_SEL, RS_DATA, MEM_RDATA, MEM_ACK,
    input  MEM_REQ, MEM_ADDR, INSTRUCTION, IR_VALID, PC, FAULT
  );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: increment, branch, jump, jump-register.
// All arithmetic wraps modulo 2^ADDR_WIDTH.
module next_pc_calc
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  npc_sel_e              npc_sel,
  output logic [ADDR_WIDTH-1:0] npc_c
);

  logic [ADDR_WIDTH-1:0] pc1;
  logic [ADDR_WIDTH-1:0] branch_tgt;
  logic [ADDR_WIDTH-1:0] jump_tgt;
  logic                  unused_bits;

  assign pc1        = pc + ADDR_WIDTH'(1);
  assign branch_tgt = pc1 + ADDR_WIDTH'($signed(instruction[IMM_WIDTH-1:0]));

  // Wide PCs keep the upper region of PC+1; narrow PCs take the jump field directly.
  generate
    if (ADDR_WIDTH > JUMP_WIDTH) begin : g_jump_wide
      assign jump_tgt = {pc1[ADDR_WIDTH-1:JUMP_WIDTH], instruction[JUMP_WIDTH-1:0]};
    end else begin : g_jump_narrow
      assign jump_tgt = instruction[ADDR_WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    npc_c = pc1;
    case (npc_sel)
      NPC_INC:    npc_c = pc1;
      NPC_BRANCH: npc_c = branch_tgt;
      NPC_JUMP:   npc_c = jump_tgt;
      NPC_JR:     npc_c = rs_data[ADDR_WIDTH-1:0];
      default:    npc_c = pc1;
    endcase
  end

  assign unused_bits = ^{instruction, rs_data};

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, instruction register and request/acknowledge fetch FSM.
// Define FETCH_TIMEOUT_EN to build in the REQ watchdog and the sticky FAULT state.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 26,
  parameter int unsigned INST_START_ADDR = 'h1000,
  parameter int unsigned TIMEOUT_CYCLES  = 16
) (
  input logic             CLK,
  input logic             RST,
  pc_fetch_unit_if.master bus
);

  state_e                state_q;
  state_e                state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] npc;
  logic [DATA_WIDTH-1:0] ir_q;
  logic [DATA_WIDTH-1:0] ir_d;
  logic                  mem_req_q;
  logic                  ir_valid_q;
  logic                  timeout_c;

  next_pc_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc          (pc_q),
    .instruction (ir_q),
    .rs_data     (bus.RS_DATA),
    .npc_sel     (npc_sel_e'(bus.NPC_SEL)),
    .npc_c       (npc)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, PC and IR; FLUSH outranks ACK, ACK outranks timeout
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.PC_UPDATE) pc_d    = npc;
        if (bus.FETCH)     state_d = ST_REQ;
      end
      ST_REQ: begin
        if (bus.FLUSH) begin
          state_d = ST_IDLE;
        end else if (bus.MEM_ACK) begin
          ir_d    = bus.MEM_RDATA;
          state_d = ST_VALID;
        end else if (timeout_c) begin
          state_d = ST_FAULT;
        end
      end
      ST_VALID: state_d = ST_IDLE;
      ST_FAULT: if (bus.FLUSH) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered strobes, which track the state being entered
  always_ff @(posedge CLK) begin
    if (!RST) begin
      pc_q       <= ADDR_WIDTH'(INST_START_ADDR);
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mem_req_q  <= (state_d == ST_REQ);
      ir_valid_q <= (state_d == ST_VALID);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_WIDTH-1:0] wd_cnt_q;
  logic                 fault_q;

  // Counts completed REQ cycles; restarts from zero on every entry into REQ
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wd_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == ST_REQ && state_d == ST_REQ) ? wd_cnt_q + CNT_WIDTH'(1)
                                                            : '0;
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign timeout_c = (wd_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign bus.FAULT = fault_q;
`else
  logic unused_cfg;

  assign timeout_c  = 1'b0;
  assign bus.FAULT  = 1'b0;
  assign unused_cfg = ^32'(TIMEOUT_CYCLES);
`endif

  assign bus.MEM_REQ     = mem_req_q;
  assign bus.MEM_ADDR    = pc_q;
  assign bus.INSTRUCTION = ir_q;
  assign bus.IR_VALID    = ir_valid_q;
  assign bus.PC          = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a next-PC reference model.
// Timeout checks apply when FETCH_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4 here).
module tb_pc_fetch_unit;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 26;
  localparam int unsigned AW16 = 16;

  logic CLK;
  logic RST;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pc_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW))   bus ();
  pc_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW16)) bus16 ();

  pc_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INST_START_ADDR('h1000), .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  pc_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW16), .INST_START_ADDR('h1000), .TIMEOUT_CYCLES(4)
  ) dut16 (
    .CLK(CLK), .RST(RST), .bus(bus16)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  longint unsigned m_pc;
  longint unsigned m_ir;

  // Reference next-PC written as plain modular arithmetic
  function automatic longint unsigned model_npc(input int sel, input longint unsigned pc,
                                                input longint unsigned ir,
                                                input longint unsigned rs, input int aw);
    longint unsigned mask;
    longint unsigned pc1;
    longint          imm;
    mask = (64'd1 << aw) - 64'd1;
    pc1  = (pc + 64'd1) & mask;
    imm  = longint'(ir & 64'hFFFF);
    if (imm >= 'h8000) imm = imm - 'h10000;
    case (sel)
      0:       return pc1;
      1:       return (pc1 + longint'(imm)) & mask;
      2:       if (aw > 26) return (((pc1 >> 26) << 26) | (ir & 64'h3FFFFFF)) & mask;
               else         return ir & mask;
      default: return rs & mask;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.FETCH = 1'b0;  bus.FLUSH = 1'b0;  bus.PC_UPDATE = 1'b0;  bus.NPC_SEL = 2'd0;
    bus.RS_DATA = '0;  bus.MEM_RDATA = '0; bus.MEM_ACK = 1'b0;
    bus16.FETCH = 1'b0; bus16.FLUSH = 1'b0; bus16.PC_UPDATE = 1'b0; bus16.NPC_SEL = 2'd0;
    bus16.RS_DATA = '0; bus16.MEM_RDATA = '0; bus16.MEM_ACK = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},       64'(bus.PC), 64'h1000);
    chk({tag, "_instr"},    64'(bus.INSTRUCTION), 64'd0);
    chk({tag, "_ir_valid"}, 64'(bus.IR_VALID), 64'd0);
    chk({tag, "_mem_req"},  64'(bus.MEM_REQ), 64'd0);
    chk({tag, "_fault"},    64'(bus.FAULT), 64'd0);
  endtask

  task automatic do_update(input int sel, input logic [31:0] rs);
    longint unsigned exp_pc;
    exp_pc = model_npc(sel, m_pc, m_ir, 64'(rs), AW);
    bus.PC_UPDATE = 1'b1; bus.NPC_SEL = 2'(sel); bus.RS_DATA = rs;
    step();
    bus.PC_UPDATE = 1'b0;
    m_pc = exp_pc;
    chk("pc_update", 64'(bus.PC), m_pc);
  endtask

  task automatic do_fetch(input logic [31:0] data, input int waits, input bit upd, input int sel);
    if (upd) begin
      m_pc = model_npc(sel, m_pc, m_ir, 64'd0, AW);
      bus.PC_UPDATE = 1'b1; bus.NPC_SEL = 2'(sel); bus.RS_DATA = '0;
    end
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0; bus.PC_UPDATE = 1'b0;
    chk("req_high", 64'(bus.MEM_REQ), 64'd1);
    chk("req_addr", 64'(bus.MEM_ADDR), m_pc);
    for (int i = 0; i < waits; i++) begin
      step();
      chk("req_wait", 64'(bus.MEM_REQ), 64'd1);
    end
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = data;
    step();
    bus.MEM_ACK = 1'b0;
    m_ir = 64'(data);
    chk("ir_valid_pulse", 64'(bus.IR_VALID), 64'd1);
    chk("instr_latched",  64'(bus.INSTRUCTION), m_ir);
    chk("req_drop",       64'(bus.MEM_REQ), 64'd0);
    step();
    chk("ir_valid_end", 64'(bus.IR_VALID), 64'd0);
    chk("pc_after",     64'(bus.PC), m_pc);
  endtask

  initial begin
    clear_inputs();
    RST = 1'b0;
    step();
    step();
    RST = 1'b1;
    m_pc = 64'h1000;
    m_ir = 64'd0;
    check_reset_values("reset");

    // Zero-wait fetch from the start address
    do_fetch(32'h20010005, 0, 1'b0, 0);
    chk("first_pc_hold", 64'(bus.PC), 64'h1000);

    // Backward branch then absolute jump
    do_fetch(32'h0000FFFE, 1, 1'b0, 0);
    do_update(1, 32'd0);
    chk("branch_tgt", 64'(bus.PC), 64'h0FFF);
    do_fetch(32'h00000040, 2, 1'b0, 0);
    do_update(2, 32'd0);
    chk("jump_tgt", 64'(bus.PC), 64'h40);

    // Simultaneous FETCH and PC_UPDATE uses the updated PC
    do_update(3, 32'h1000);
    do_fetch(32'h12345678, 0, 1'b1, 0);
    chk("fetch_upd_addr", 64'(bus.PC), 64'h1001);

    // FETCH while VALID is ignored
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hCAFE0001;
    step();
    bus.MEM_ACK = 1'b0; bus.FETCH = 1'b1;
    m_ir = 64'hCAFE0001;
    chk("valid_pulse", 64'(bus.IR_VALID), 64'd1);
    step();
    bus.FETCH = 1'b0;
    chk("valid_fetch_ign", 64'(bus.MEM_REQ), 64'd0);
    chk("valid_instr", 64'(bus.INSTRUCTION), m_ir);

    // FLUSH in second wait cycle discards same-cycle and later ACKs
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0; bus.PC_UPDATE = 1'b1; bus.NPC_SEL = 2'd0;
    step();
    bus.PC_UPDATE = 1'b0;
    chk("req_pc_upd_ign", 64'(bus.PC), m_pc);
    chk("flush_req_before", 64'(bus.MEM_REQ), 64'd1);
    bus.FLUSH = 1'b1; bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'hDEADBEEF;
    step();
    bus.FLUSH = 1'b0;
    chk("flush_req_drop", 64'(bus.MEM_REQ), 64'd0);
    chk("flush_no_valid", 64'(bus.IR_VALID), 64'd0);
    chk("flush_instr", 64'(bus.INSTRUCTION), m_ir);
    step();
    bus.MEM_ACK = 1'b0;
    chk("late_ack_valid", 64'(bus.IR_VALID), 64'd0);
    chk("late_ack_instr", 64'(bus.INSTRUCTION), m_ir);

`ifdef FETCH_TIMEOUT_EN
    // Four REQ cycles without ACK raise FAULT
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wd_no_fault", 64'(bus.FAULT), 64'd0);
      step();
    end
    chk("wd_req4", 64'(bus.MEM_REQ), 64'd1);
    step();
    chk("wd_fault", 64'(bus.FAULT), 64'd1);
    chk("wd_req_low", 64'(bus.MEM_REQ), 64'd0);
    bus.FETCH = 1'b1; bus.PC_UPDATE = 1'b1;
    step();
    bus.FETCH = 1'b0; bus.PC_UPDATE = 1'b0;
    chk("fault_fetch_ign", 64'(bus.MEM_REQ), 64'd0);
    chk("fault_sticky", 64'(bus.FAULT), 64'd1);
    chk("fault_pc_hold", 64'(bus.PC), m_pc);
    bus.FLUSH = 1'b1;
    step();
    bus.FLUSH = 1'b0;
    chk("fault_cleared", 64'(bus.FAULT), 64'd0);
    // ACK on the limit cycle wins over the timeout
    do_fetch($urandom(), 3, 1'b0, 0);
    chk("ack_at_limit", 64'(bus.FAULT), 64'd0);
`else
    // Without the watchdog REQ waits indefinitely
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("long_wait_req", 64'(bus.MEM_REQ), 64'd1);
    chk("long_wait_fault", 64'(bus.FAULT), 64'd0);
    bus.MEM_ACK = 1'b1; bus.MEM_RDATA = 32'h0BADF00D;
    step();
    bus.MEM_ACK = 1'b0;
    m_ir = 64'h0BADF00D;
    chk("long_wait_valid", 64'(bus.IR_VALID), 64'd1);
    step();
`endif

    // Randomized updates and fetches
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 1)
        do_update(int'($urandom_range(3, 0)), $urandom());
      else
        do_fetch($urandom(), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
                 int'($urandom_range(3, 0)));
    end

    // Reset in the middle of a request
    bus.FETCH = 1'b1;
    step();
    bus.FETCH = 1'b0;
    chk("pre_reset_req", 64'(bus.MEM_REQ), 64'd1);
    RST = 1'b0;
    step();
    check_reset_values("midreset");
    RST = 1'b1;
    m_pc = 64'h1000;
    m_ir = 64'd0;

    // 16-bit PC wraps from all-ones to zero
    bus16.RS_DATA = 32'h0000FFFF; bus16.NPC_SEL = 2'd3; bus16.PC_UPDATE = 1'b1;
    step();
    chk("aw16_jr", 64'(bus16.PC), model_npc(3, 64'h1000, 64'd0, 64'hFFFF, AW16));
    bus16.NPC_SEL = 2'd0;
    step();
    bus16.PC_UPDATE = 1'b0;
    chk("aw16_wrap", 64'(bus16.PC), model_npc(0, 64'hFFFF, 64'd0, 64'd0, AW16));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
